// File: rtl/lift_request_scheduler.sv
// SCAN request scheduler for the lift: syncs buttons/status, latches presses, dispatches one-hot targets.
// Optional LIFT_REQ_RETARGET_EN: retarget to an intermediate pending floor while waiting for the door.
module lift_request_scheduler #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] btn,
   input  logic [1:0] cur_floor,
   input  logic       open_door,
   output logic [3:0] floor_request,
   output logic [3:0] pending,
   output logic       dir_up,
   output logic       busy
);

   typedef enum logic [2:0] {IDLE, SELECT, DISPATCH, WAIT_OPEN, WAIT_CLOSE} state_t;

   logic [SYNC_STAGES-1:0][3:0] btn_sync_q, btn_sync_d;
   logic [SYNC_STAGES-1:0][1:0] cur_sync_q, cur_sync_d;
   logic [SYNC_STAGES-1:0]      door_sync_q, door_sync_d;
   logic [3:0] btn_prev_q, btn_prev_d;
   logic [3:0] pending_q, pending_d;
   logic [3:0] floor_request_q, floor_request_d;
   logic [1:0] target_q, target_d;
   logic       dir_up_q, dir_up_d;
   logic       busy_q, busy_d;
   state_t     state_q, state_d;

   logic [3:0] btn_s, set_mask, clr_mask, drop_mask;
   logic [1:0] cur_s;
   logic       door_s;
   logic [2:0] pick;

   assign btn_s  = btn_sync_q[SYNC_STAGES-1];
   assign cur_s  = cur_sync_q[SYNC_STAGES-1];
   assign door_s = door_sync_q[SYNC_STAGES-1];

   // {found, floor}: nearest pending floor strictly between lo and hi, from the low or high side
   function automatic logic [2:0] lowest_in(input logic [3:0] p, input int lo, input int hi);
      lowest_in = 3'b000;
      for (int i = 3; i >= 0; i--)
         if (i > lo && i < hi && p[i]) lowest_in = {1'b1, 2'(i)};
   endfunction

   function automatic logic [2:0] highest_in(input logic [3:0] p, input int lo, input int hi);
      highest_in = 3'b000;
      for (int i = 0; i <= 3; i++)
         if (i > lo && i < hi && p[i]) highest_in = {1'b1, 2'(i)};
   endfunction

   always_comb begin
      btn_sync_d      = {btn_sync_q[SYNC_STAGES-2:0], btn};
      cur_sync_d      = {cur_sync_q[SYNC_STAGES-2:0], cur_floor};
      door_sync_d     = {door_sync_q[SYNC_STAGES-2:0], open_door};
      btn_prev_d      = btn_s;
      floor_request_d = floor_request_q;
      target_d        = target_q;
      dir_up_d        = dir_up_q;
      state_d         = state_q;
      clr_mask        = 4'b0000;
      pick            = 3'b000;
      // the door is already open here, so a press for this floor is moot
      drop_mask       = (state_q == WAIT_CLOSE) ? (4'b0001 << cur_s) : 4'b0000;
      set_mask        = btn_s & ~btn_prev_q & ~drop_mask;

      case (state_q)
         IDLE: if (pending_q != 4'b0000) state_d = SELECT;
         SELECT: begin
            state_d = DISPATCH;
            if (pending_q[cur_s]) begin
               target_d = cur_s;
            end else if (dir_up_q) begin
               pick = lowest_in(pending_q, int'(cur_s), 4);
               if (!pick[2]) begin
                  dir_up_d = 1'b0;
                  pick     = highest_in(pending_q, -1, int'(cur_s));
               end
               target_d = pick[1:0];
            end else begin
               pick = highest_in(pending_q, -1, int'(cur_s));
               if (!pick[2]) begin
                  dir_up_d = 1'b1;
                  pick     = lowest_in(pending_q, int'(cur_s), 4);
               end
               target_d = pick[1:0];
            end
         end
         DISPATCH: begin
            floor_request_d = 4'b0001 << target_q;
            state_d         = WAIT_OPEN;
         end
         WAIT_OPEN: begin
            if (door_s && cur_s == target_q) begin
               clr_mask        = 4'b0001 << target_q;
               floor_request_d = 4'b0000;
               state_d         = WAIT_CLOSE;
            end
`ifdef LIFT_REQ_RETARGET_EN
            else begin
               if (target_q > cur_s)
                  pick = lowest_in(pending_q, int'(cur_s), int'(target_q));
               else if (target_q < cur_s)
                  pick = highest_in(pending_q, int'(target_q), int'(cur_s));
               if (pick[2]) begin
                  target_d        = pick[1:0];
                  floor_request_d = 4'b0001 << pick[1:0];
               end
            end
`endif
         end
         WAIT_CLOSE: begin
            floor_request_d = 4'b0000;
            if (!door_s) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      pending_d = (pending_q | set_mask) & ~clr_mask;
      busy_d    = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         btn_sync_q      <= '0;
         cur_sync_q      <= '0;
         door_sync_q     <= '0;
         btn_prev_q      <= 4'b0000;
         pending_q       <= 4'b0000;
         floor_request_q <= 4'b0000;
         target_q        <= 2'd0;
         dir_up_q        <= 1'b1;
         busy_q          <= 1'b0;
         state_q         <= IDLE;
      end else begin
         btn_sync_q      <= btn_sync_d;
         cur_sync_q      <= cur_sync_d;
         door_sync_q     <= door_sync_d;
         btn_prev_q      <= btn_prev_d;
         pending_q       <= pending_d;
         floor_request_q <= floor_request_d;
         target_q        <= target_d;
         dir_up_q        <= dir_up_d;
         busy_q          <= busy_d;
         state_q         <= state_d;
      end
   end

   assign floor_request = floor_request_q;
   assign pending       = pending_q;
   assign dir_up        = dir_up_q;
   assign busy          = busy_q;

endmodule

// File: doc/lift_request_scheduler.md
Name: lift_request_scheduler

Overview:
- Upstream request stage for the lift controller.
- Captures asynchronous floor-button presses into a pending set and selects the next target floor using SCAN, i.e. it keeps the current travel direction while requests remain ahead.
- Drives the lift's one-hot floor_request, holding it until the lift opens its door at that floor.
- Runs on the fast board clock. Lift status arrives from the divided-clock domain and is synchronised inside this block.

Parameters:
- SYNC_STAGES, 2, synchroniser depth for btn, cur_floor and open_door (minimum 2).

Ports:
- clk  input  1  board clock
- rst  input  1  reset, asynchronous, active-high
- btn  input  4  raw floor buttons, bit i = floor i, asynchronous, level
- cur_floor  input  2  lift's current floor (binary)
- open_door  input  1  lift door-open indicator
- floor_request  output  4  one-hot target floor to the lift, or 0000 when none
- pending  output  4  latched unserved requests
- dir_up  output  1  current SCAN direction, 1 = up
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async): state IDLE, floor_request=0000, pending=0000, dir_up=1, busy=0, target=0, all sync/edge flops cleared.
- Input sync: btn, cur_floor and open_door each pass through SYNC_STAGES flops. cur_floor and open_door are stable for millions of clk cycles, so multi-bit sync of cur_floor is acceptable.
- Button capture:
  - A rising edge of synced btn[i] sets pending[i].
  - With SYNC_STAGES=2, pending[i] rises on the 3rd clk edge after btn[i] rises.
  - A held button sets the bit only once.
- Press at the open floor: a press for floor f is dropped while state is WAIT_CLOSE and synced cur_floor==f (door already open there).
- Set/clear collision: if set and clear of the same pending bit fall in one cycle, clear wins.
- FSM states: IDLE, SELECT, DISPATCH, WAIT_OPEN, WAIT_CLOSE.
- IDLE: pending!=0 -> SELECT, otherwise stay.
- SELECT (exactly 1 cycle): compute target from pending and synced cur_floor, then -> DISPATCH.
  - Rule 1: if pending[cur_floor], target=cur_floor and dir_up is unchanged.
  - Rule 2: else if dir_up, target = lowest pending floor above cur_floor, if one exists.
  - Rule 3: else if !dir_up, target = highest pending floor below cur_floor, if one exists.
  - Rule 4: if rule 2/3 finds none, toggle dir_up and apply the opposite rule.
- DISPATCH (1 cycle): register floor_request = onehot(target), then -> WAIT_OPEN.
  - floor_request is registered, so it is first visible on the cycle after DISPATCH.
- WAIT_OPEN:
  - Hold floor_request constant.
  - When synced open_door==1 and synced cur_floor==target, clear pending[target], set floor_request=0000 on the same edge, and go to WAIT_CLOSE.
  - The request drops to zero so the lift does not re-open when it returns to idle.
- WAIT_CLOSE: floor_request=0000. On synced open_door==0 -> IDLE.
- open_door at the wrong floor (cur_floor!=target while in WAIT_OPEN) is ignored; stay in WAIT_OPEN.
- floor_request is always either one-hot or 0000; it is never multi-hot.
- Mid-operation reset returns everything to reset values immediately and discards pending requests.
- Latency, button press to floor_request asserted (lift idle, SYNC_STAGES=2): 3 cycles to pending, +1 IDLE->SELECT, +1 SELECT->DISPATCH, +1 registered output = 6 clk edges.

Optional Feature:
- Macro: LIFT_REQ_RETARGET_EN.
- Defined: in WAIT_OPEN, when a pending floor p satisfies cur_floor < p < target (going up) or target < p < cur_floor (going down), target becomes p and floor_request updates on the next cycle. The original target stays pending.
- Undefined: target is frozen from DISPATCH until served; intermediate requests wait for the next SELECT.

Test Plan:
- Reset, then btn=0100 with cur_floor=0 -> pending=0100 after 3 cycles, floor_request=0100 on edge 6, dir_up=1, busy=1.
- Continuing: cur_floor=2 and open_door=1 -> pending=0000, floor_request=0000 (after sync delay). Then open_door=0 -> IDLE, busy=0.
- cur_floor=1, dir_up=1, pending=1001 -> first target 3 (1000). After serving, target 0 (0001) with dir_up=0.
- btn=0001 pressed while state=WAIT_CLOSE at cur_floor=0 -> pending stays 0000. Same press while cur_floor=2 -> pending=0001.
- Target 3 from floor 0, btn=0010 pressed in WAIT_OPEN:
  - Macro defined: floor_request -> 0010.
  - Macro undefined: floor_request stays 1000 and pending=1010.
- Assert rst during WAIT_OPEN with pending=0110 -> floor_request=0000, pending=0000, dir_up=1 immediately, without waiting for clk.
